// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle for uart_tx_arbiter.
//   req_valid_in  : per-requester byte-valid
//   req_data_in   : requester i's byte at [8i+7:8i]
//   req_ready_out : one-hot accept strobe, transfer on valid & ready
// master = byte producers, slave = the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid_in;
    logic [8*NUM_REQ-1:0] req_data_in;
    logic [NUM_REQ-1:0]   req_ready_out;

    modport master (
        output req_valid_in,
        output req_data_in,
        input  req_ready_out
    );

    modport slave (
        input  req_valid_in,
        input  req_data_in,
        output req_ready_out
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one 8N1 UART transmitter
// among NUM_REQ byte producers.
//
// Optional feature macro: UART_ARB_PARITY_EN
//   defined   -> an even-parity bit is sent between the data and stop bits
//   undefined -> plain 8N1 framing
//
// Ports:
//   clk_in       : system clock
//   rst_in       : synchronous, active-high reset
//   req          : requester handshake bundle (slave modport)
//   tx_out       : serial line, idle high, registered
//   busy_out     : high while a frame is in flight
//   grant_id_out : index of the last granted requester
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CYCLES_PER_BIT = 868
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    uart_tx_arbiter_if.slave           req,
    output logic                       tx_out,
    output logic                       busy_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_out
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CYCLES_PER_BIT);

`ifdef UART_ARB_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         byte_q;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_nxt;
    logic [IDW-1:0]     grant_q;
    logic               tx_q, tx_d;
    logic [IDW-1:0]     win;
    logic               win_vld;
    logic               bit_end;
    logic               take;

    assign bit_end = (bit_cnt_q == CNT_W'(CYCLES_PER_BIT - 1));
    assign take    = (state_q == IDLE) && win_vld;

    // Winner: first valid index at or after rr_ptr, searching upward with wrap.
    always_comb begin
        int j;
        j       = 0;
        win_vld = 1'b0;
        win     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_vld && req.req_valid_in[IDW'(j)]) begin
                win_vld = 1'b1;
                win     = IDW'(j);
            end
        end
    end

    assign rr_ptr_nxt = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (win_vld) state_d = START;
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end && bit_idx_q == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
                       state_d = PARITY;
`else
                       state_d = STOP;
`endif
                   end
`ifdef UART_ARB_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP:  if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: ready strobe, counters' next values and the next line level.
    // tx is computed from the next state so the flop shows the start bit in the
    // cycle right after the grant.
    always_comb begin
        req.req_ready_out = '0;
        if (take && !rst_in) req.req_ready_out = NUM_REQ'(1) << win;

        bit_cnt_d = '0;
        if (state_q != IDLE && !bit_end) bit_cnt_d = bit_cnt_q + CNT_W'(1);

        bit_idx_d = bit_idx_q;
        if (state_q == IDLE)                bit_idx_d = 3'd0;
        else if (state_q == DATA && bit_end) bit_idx_d = bit_idx_q + 3'd1;

        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = byte_q[bit_idx_d];
`ifdef UART_ARB_PARITY_EN
            PARITY: tx_d = ^byte_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            if (take) begin
                byte_q   <= req.req_data_in[{win, 3'b000} +: 8];
                grant_q  <= win;
                rr_ptr_q <= rr_ptr_nxt;
            end
        end
    end

    assign tx_out       = tx_q;
    assign busy_out     = (state_q != IDLE);
    assign grant_id_out = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int CPB = 4;
`ifdef UART_ARB_PARITY_EN
    localparam int FB  = 11;
`else
    localparam int FB  = 10;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       tx_out, busy_out;
    logic [1:0] grant_id_out;

    uart_tx_arbiter_if #(.NUM_REQ(N)) req_if ();

    uart_tx_arbiter #(.NUM_REQ(N), .CYCLES_PER_BIT(CPB)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .req          (req_if.slave),
        .tx_out       (tx_out),
        .busy_out     (busy_out),
        .grant_id_out (grant_id_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0, n_err = 0, cyc = 0;
    logic [N-1:0]   vld = '0;
    logic [8*N-1:0] dat = '0;
    logic           rst = 1'b1;
    logic [N-1:0]   rdy_obs;
    logic           tx_obs, busy_obs;

    // Frame-level reference: a queue of expected line levels for coming cycles.
    bit   q[$];
    logic m_tx = 1'b1, m_busy = 1'b0;
    int   m_gid = 0, m_ptr = 0;
    int   g_id[8], g_t[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic void push_frame(input logic [7:0] d);
        repeat (CPB) q.push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (CPB) q.push_back(d[b]);
`ifdef UART_ARB_PARITY_EN
        repeat (CPB) q.push_back(^d);
`endif
        repeat (CPB) q.push_back(1'b1);
    endfunction

    // One clock: drive at the falling edge, check 1 time unit later, advance model.
    task automatic step();
        int w;
        logic [N-1:0] rdy_exp;
        @(negedge clk_in);
        req_if.req_valid_in = vld;
        req_if.req_data_in  = dat;
        rst_in              = rst;
        #1;
        cyc++;
        rdy_obs  = req_if.req_ready_out;
        tx_obs   = tx_out;
        busy_obs = busy_out;
        w = rr_pick(vld, m_ptr);
        rdy_exp = (!rst && !m_busy && w >= 0) ? (N'(1) << w) : '0;
        chk("tx", tx_obs, m_tx);
        chk("busy", busy_obs, m_busy);
        chk("gid", grant_id_out, m_gid);
        chk("ready", rdy_obs, rdy_exp);
        if (rst) begin
            q.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_gid = 0; m_ptr = 0;
        end else begin
            if (!m_busy && w >= 0) begin
                m_gid = w;
                m_ptr = (w + 1) % N;
                push_frame(dat[w*8 +: 8]);
            end
            if (q.size() > 0) begin
                m_tx = q.pop_front(); m_busy = 1'b1;
            end else begin
                m_tx = 1'b1; m_busy = 1'b0;
            end
        end
    endtask

    task automatic do_rst();
        vld = '0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    // Run until n grants seen; granted requesters get a fresh byte and stay valid.
    task automatic collect(input int n, input string tag);
        int got = 0;
        for (int c = 0; c < n * (FB * CPB + 2) + 20 && got < n; c++) begin
            step();
            if (rdy_obs != '0) begin
                for (int i = 0; i < N; i++)
                    if (rdy_obs[i]) begin
                        g_id[got] = i;
                        dat[i*8 +: 8] = 8'($urandom);
                    end
                g_t[got] = cyc;
                got++;
            end
        end
        chk({tag, "_grants"}, got, n);
    endtask

    // Called in the grant cycle: decode the following frame from the line.
    task automatic rx_frame(output logic [7:0] b, output logic p, output int len, output int xr);
        int t, k;
        b = '0; p = 1'b0; xr = 0;
        for (t = 1; t <= FB * CPB + 20; t++) begin
            step();
            if (!busy_obs) break;
            if (rdy_obs != '0) xr++;
            if ((t - 1) % CPB == CPB / 2) begin
                k = (t - 1) / CPB;
                if (k >= 1 && k <= 8) b[k-1] = tx_obs;
                if (k == 9) p = tx_obs;
            end
        end
        len = t - 1;
    endtask

    initial begin
        logic [FB-1:0] ex;
        logic [7:0] rb;
        logic       rp;
        int         len, xr;
        req_if.req_valid_in = '0;
        req_if.req_data_in  = '0;

        // Reset state, then single request from req 2 with 0xA5.
        repeat (3) step();
        rst = 1'b0;
        while (cyc < 9) step();
        vld = 4'b0100; dat[23:16] = 8'hA5;
        step();
        chk("a_ready", rdy_obs, 4'b0100);
        vld = '0;
        step();
        chk("a_gid", grant_id_out, 2);
`ifdef UART_ARB_PARITY_EN
        ex = {1'b1, ^8'hA5, 8'hA5, 1'b0};
`else
        ex = {1'b1, 8'hA5, 1'b0};
`endif
        for (int i = 0; i < FB * CPB; i++) begin
            if (i % CPB == CPB / 2) chk("a_bit", tx_obs, ex[i/CPB]);
            step();
        end
        chk("a_busy_fall", busy_obs, 0);

        // All four requesters valid continuously.
        do_rst();
        vld = 4'hF; dat = $urandom;
        collect(5, "b");
        for (int i = 0; i < 5; i++) chk("b_order", g_id[i], i % N);
        for (int i = 0; i < 4; i++) chk("b_spacing", g_t[i+1] - g_t[i], FB * CPB + 1);

        // Fairness between req0 and req3.
        do_rst();
        vld = 4'b1001;
        collect(4, "c");
        for (int i = 0; i < 4; i++) chk("c_order", g_id[i], (i % 2) ? 3 : 0);

        // Reset during data bit 3, then a clean frame.
        do_rst();
        vld = 4'b0010; dat[15:8] = 8'h5A;
        collect(1, "d");
        vld = '0;
        repeat (4 * CPB + 1) step();
        chk("d_midframe", busy_obs, 1);
        rst = 1'b1; step(); rst = 1'b0;
        step();
        chk("d_tx", tx_obs, 1);
        chk("d_busy", busy_obs, 0);
        chk("d_gid", grant_id_out, 0);
        vld = 4'b0100; dat[23:16] = 8'hC3;
        collect(1, "d2");
        vld = '0;
        rx_frame(rb, rp, len, xr);
        chk("d_byte", rb, 8'hC3);
        chk("d_len", len, FB * CPB);

        // Mid-frame input changes are ignored.
        do_rst();
        vld = 4'b0001; dat[7:0] = 8'h3C;
        collect(1, "e");
        vld = '0; dat = 32'hFFFF_FFFF;
        rx_frame(rb, rp, len, xr);
        chk("e_byte", rb, 8'h3C);
        chk("e_extra_rdy", xr, 0);
        chk("e_len", len, FB * CPB);

        // Byte 0x07: three ones, so even parity is 1.
        do_rst();
        vld = 4'b1000; dat[31:24] = 8'h07;
        collect(1, "f");
        vld = '0;
        rx_frame(rb, rp, len, xr);
        chk("f_byte", rb, 8'h07);
        chk("f_len", len, FB * CPB);
`ifdef UART_ARB_PARITY_EN
        chk("f_parity", rp, 1);
`endif

        // Random traffic with occasional resets and withdrawals.
        do_rst();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (vld[i] && rdy_obs[i]) begin
                    vld[i] = 1'($urandom);
                    dat[i*8 +: 8] = 8'($urandom);
                end else if (!vld[i] && $urandom_range(0, 3) == 0) begin
                    vld[i] = 1'b1;
                    dat[i*8 +: 8] = 8'($urandom);
                end else if (vld[i] && $urandom_range(0, 49) == 0) begin
                    vld[i] = 1'b0;
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
